// File: rtl/wishbone_slave_mem.sv
// Wishbone point-to-point slave memory with programmable wait states,
// byte-lane writes, out-of-range error termination and periodic retry.
// Terminations are registered: ack/err/rty are high for exactly the one
// cycle the FSM spends in S_RESP.
module wishbone_slave_mem #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter int                    RTY_EVERY   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [7:0]            sel,
    input  logic                  cyc,
    input  logic                  stb,
    input  logic                  we,
    input  logic                  lock,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ack,
    output logic                  err,
    output logic                  rty
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] SPAN    = (ADDR_WIDTH+1)'(MEM_DEPTH * NB);
    localparam logic [3:0]          WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [15:0]         RTY_N   = (RTY_EVERY > 0) ? 16'(RTY_EVERY) : 16'd1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {TERM_ACK, TERM_ERR, TERM_RTY} term_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_q, state_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [15:0]           acc_q, acc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  we_q, we_d;
    logic [NB-1:0]         sel_q, sel_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    term_t                 term_q, term_d;
    logic                  ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [ADDR_WIDTH:0]   off_ext;
    logic [IDX_W-1:0]      idx_live;
    term_t                 term_live;
    logic                  fire;
    logic                  mem_we;
    logic [IDX_W-1:0]      f_idx;
    logic                  f_we;
    logic [NB-1:0]         f_sel;
    logic [DATA_WIDTH-1:0] f_wdata;
    term_t                 f_term;
    logic                  unused_ok;

    // One extra bit makes adr < BASE_ADDR wrap to a huge offset, so a single
    // compare against SPAN covers both range limits.
    assign off_ext  = {1'b0, adr} - {1'b0, BASE_ADDR};
    assign idx_live = off_ext[OFF_W +: IDX_W];
    assign unused_ok = &{1'b0, lock, sel, off_ext};

    // Termination class of the access currently on the bus.
    always_comb begin
        term_live = TERM_ACK;
        if (off_ext >= SPAN)
            term_live = TERM_ERR;
        else if (RTY_EVERY > 0 && (acc_q % RTY_N) == (RTY_N - 16'd1))
            term_live = TERM_RTY;
    end

    // FSM next state, capture, termination and write-enable generation.
    // "fire" marks the edge that enters S_RESP; with zero wait states the
    // live bus fields are used directly, otherwise the captured ones.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        term_d  = term_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;
        rdata_d = rdata_q;
        fire    = 1'b0;
        mem_we  = 1'b0;
        f_idx   = idx_q;
        f_we    = we_q;
        f_sel   = sel_q;
        f_wdata = wdata_q;
        f_term  = term_q;
        case (state_q)
            S_IDLE: begin
                if (cyc && stb) begin
                    idx_d   = idx_live;
                    we_d    = we;
                    sel_d   = sel[NB-1:0];
                    wdata_d = wdata;
                    term_d  = term_live;
                    wcnt_d  = WS_LOAD;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        fire    = 1'b1;
                        f_idx   = idx_live;
                        f_we    = we;
                        f_sel   = sel[NB-1:0];
                        f_wdata = wdata;
                        f_term  = term_live;
                    end
                end
            end
            S_WAIT: begin
                if (!cyc)
                    state_d = S_IDLE;
                else if (wcnt_q == 4'd0)
                    fire = 1'b1;
                else
                    wcnt_d = wcnt_q - 4'd1;
            end
            // stb is still held by the master here and must not start a new access
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (fire) begin
            state_d = S_RESP;
            ack_d   = (f_term == TERM_ACK);
            err_d   = (f_term == TERM_ERR);
            rty_d   = (f_term == TERM_RTY);
            rdata_d = (f_term == TERM_ACK) ? mem[f_idx] : '0;
            mem_we  = (f_term == TERM_ACK) && f_we;
            if (f_term != TERM_ERR)
                acc_d = acc_q + 16'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            acc_q   <= 16'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
            term_q  <= TERM_ACK;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            term_q  <= term_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            rdata_q <= rdata_d;
        end
    end

    // Byte-lane memory write on the edge that raises ack; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < NB; i++)
                if (f_sel[i])
                    mem[f_idx][8*i +: 8] <= f_wdata[8*i +: 8];
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign rty   = rty_q;
endmodule

// File: tb/tb_wishbone_slave_mem.sv
// Scoreboard bench for wishbone_slave_mem: three instances cover zero-wait
// with an offset base, three wait states, and retry injection every 3rd access.
module tb_wishbone_slave_mem;
    localparam int ND = 3;
    localparam logic [31:0] BASE [ND] = '{32'h1000, 32'h0, 32'h0};
    localparam int          WS   [ND] = '{0, 3, 0};
    localparam int          RTY  [ND] = '{0, 0, 3};
    localparam logic [2:0] K_ACK = 3'b001, K_ERR = 3'b010, K_RTY = 3'b100;

    typedef struct packed {
        logic [1:0]  dut;
        logic [2:0]  kind;
        logic [31:0] rdata;
        logic        chk;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i [ND];
    logic [31:0] adr_i [ND];
    logic [31:0] wdata_i [ND];
    logic [7:0]  sel_i [ND];
    logic        cyc_i [ND];
    logic        stb_i [ND];
    logic        we_i [ND];
    logic        lock_t = 1'b0;
    logic [31:0] rdata_o [ND];
    logic        ack_o [ND];
    logic        err_o [ND];
    logic        rty_o [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        wishbone_slave_mem #(
            .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(16), .BASE_ADDR(BASE[g]),
            .WAIT_STATES(WS[g]), .RTY_EVERY(RTY[g])
        ) dut (
            .clk(clk), .rst(rst_i[g]), .adr(adr_i[g]), .wdata(wdata_i[g]), .sel(sel_i[g]),
            .cyc(cyc_i[g]), .stb(stb_i[g]), .we(we_i[g]), .lock(lock_t),
            .rdata(rdata_o[g]), .ack(ack_o[g]), .err(err_o[g]), .rty(rty_o[g])
        );
    end

    int   cycles = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    exp_t sb_q [$];
    string       nm_q [$];
    bit          ok_q [$];
    logic [31:0] act_q [$];
    logic [31:0] req_q [$];

    always @(posedge clk) cycles <= cycles + 1;

    // Monitor: the only process that counts comparisons.
    always @(negedge clk) begin
        exp_t        e;
        logic [2:0]  k;
        bit          ok;
        string       nm;
        logic [31:0] a, r;
        while (ok_q.size() > 0) begin
            nm = nm_q.pop_front();
            ok = ok_q.pop_front();
            a  = act_q.pop_front();
            r  = req_q.pop_front();
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s: got %h expected %h", nm, a, r);
            end
        end
        if (mon_en) begin
            for (int d = 0; d < ND; d++) begin
                k = {rty_o[d], err_o[d], ack_o[d]};
                if (k != 3'b000) begin
                    total++;
                    if (sb_q.size() == 0) begin
                        bad++;
                        $display("FAIL term_unexpected dut%0d: got kind %b at cycle %0d expected none", d, k, cycles);
                    end else begin
                        e  = sb_q.pop_front();
                        ok = (e.dut == 2'(d)) && (e.kind == k) && (!e.chk || e.rdata == rdata_o[d])
                             && (e.cyc == 32'(cycles));
                        if (!ok) begin
                            bad++;
                            $display("FAIL term dut%0d: got kind %b rdata %h cycle %0d expected dut%0d kind %b rdata %h cycle %0d",
                                     d, k, rdata_o[d], cycles, e.dut, e.kind, e.rdata, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic push_chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] req);
        nm_q.push_back(nm);
        ok_q.push_back(ok);
        act_q.push_back(act);
        req_q.push_back(req);
    endtask

    // One bus access; expected termination is queued when stb goes up.
    task automatic xfer(input int d, input logic [31:0] a, input bit w, input logic [7:0] s,
                        input logic [31:0] wd, input logic [2:0] kind, input logic [31:0] rd, input bit chk);
        exp_t e;
        bit   seen;
        @(negedge clk);
        adr_i[d] = a; we_i[d] = w; sel_i[d] = s; wdata_i[d] = wd;
        cyc_i[d] = 1'b1; stb_i[d] = 1'b1;
        e.dut = 2'(d); e.kind = kind; e.rdata = rd; e.chk = chk;
        e.cyc = 32'(cycles + 1 + WS[d]);
        sb_q.push_back(e);
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (ack_o[d] || err_o[d] || rty_o[d]) seen = 1'b1;
        end
        if (!seen) push_chk("xfer_timeout", 1'b0, a, 32'h0);
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        cyc_i[d] = 1'b0; stb_i[d] = 1'b0; we_i[d] = 1'b0;
    endtask

    task automatic quiet(input int d, input int n, input string nm);
        bit q;
        q = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (ack_o[d] || err_o[d] || rty_o[d]) q = 1'b0;
        end
        push_chk(nm, q, {31'b0, q}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < ND; d++) begin
            rst_i[d] = 1'b1; adr_i[d] = '0; wdata_i[d] = '0; sel_i[d] = '0;
            cyc_i[d] = 1'b0; stb_i[d] = 1'b0; we_i[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            push_chk("reset_term", {rty_o[d], err_o[d], ack_o[d]} == 3'b000,
                     {29'b0, rty_o[d], err_o[d], ack_o[d]}, 32'h0);
            push_chk("reset_rdata", rdata_o[d] == 32'h0, rdata_o[d], 32'h0);
            rst_i[d] = 1'b0;
        end
        mon_en = 1'b1;

        // zero wait, base 0x1000: basic, lanes, low-bit aliasing, range errors
        xfer(0, 32'h1000, 1, 8'hF, 32'h5A5A5A5A, K_ACK, 32'h0, 0);
        xfer(0, 32'h1010, 1, 8'hF, 32'hDEADBEEF, K_ACK, 32'h0, 0);
        xfer(0, 32'h1010, 0, 8'hF, 32'h0,        K_ACK, 32'hDEADBEEF, 1);
        xfer(0, 32'h1013, 0, 8'hF, 32'h0,        K_ACK, 32'hDEADBEEF, 1);
        xfer(0, 32'h103C, 1, 8'hF, 32'hCAFEF00D, K_ACK, 32'h0, 0);
        xfer(0, 32'h1020, 1, 8'hF, 32'h11223344, K_ACK, 32'h0, 0);
        xfer(0, 32'h1020, 1, 8'h5, 32'hAABBCCDD, K_ACK, 32'h0, 0);
        xfer(0, 32'h1020, 0, 8'hF, 32'h0,        K_ACK, 32'h11BB33DD, 1);
        xfer(0, 32'h1040, 1, 8'hF, 32'h12345678, K_ERR, 32'h0, 1);
        xfer(0, 32'h0FFC, 1, 8'hF, 32'h12345678, K_ERR, 32'h0, 1);
        xfer(0, 32'h0FFC, 0, 8'hF, 32'h0,        K_ERR, 32'h0, 1);
        xfer(0, 32'h1000, 0, 8'hF, 32'h0,        K_ACK, 32'h5A5A5A5A, 1);
        xfer(0, 32'h103C, 0, 8'hF, 32'h0,        K_ACK, 32'hCAFEF00D, 1);
        idle(0);

        // three wait states: latency, abort in 2nd wait cycle, reset during wait
        xfer(1, 32'h8, 1, 8'hF, 32'h01020304, K_ACK, 32'h0, 0);
        xfer(1, 32'h8, 0, 8'hF, 32'h0,        K_ACK, 32'h01020304, 1);
        idle(1);
        @(negedge clk);
        adr_i[1] = 32'h8; we_i[1] = 1'b1; sel_i[1] = 8'hF; wdata_i[1] = 32'hFFFFFFFF;
        cyc_i[1] = 1'b1; stb_i[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cyc_i[1] = 1'b0; stb_i[1] = 1'b0;
        quiet(1, 8, "abort_no_term");
        push_chk("abort_idle", g_dut[1].dut.state_q == 2'd0, {30'b0, g_dut[1].dut.state_q}, 32'h0);
        xfer(1, 32'h8, 0, 8'hF, 32'h0, K_ACK, 32'h01020304, 1);
        idle(1);
        @(negedge clk);
        adr_i[1] = 32'h8; we_i[1] = 1'b1; sel_i[1] = 8'hF; wdata_i[1] = 32'h77777777;
        cyc_i[1] = 1'b1; stb_i[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_i[1] = 1'b1;
        @(negedge clk);
        push_chk("rst_term", {rty_o[1], err_o[1], ack_o[1]} == 3'b000,
                 {29'b0, rty_o[1], err_o[1], ack_o[1]}, 32'h0);
        push_chk("rst_idle", g_dut[1].dut.state_q == 2'd0, {30'b0, g_dut[1].dut.state_q}, 32'h0);
        rst_i[1] = 1'b0; cyc_i[1] = 1'b0; stb_i[1] = 1'b0;
        quiet(1, 6, "rst_no_term");
        xfer(1, 32'h8, 0, 8'hF, 32'h0, K_ACK, 32'h01020304, 1);
        idle(1);

        // retry every 3rd in-range access; err does not advance the count
        xfer(2, 32'h0,  1, 8'hF, 32'h00000100, K_ACK, 32'h0, 0);
        xfer(2, 32'h4,  1, 8'hF, 32'h00000104, K_ACK, 32'h0, 0);
        xfer(2, 32'h0,  1, 8'hF, 32'h0000BAD0, K_RTY, 32'h0, 1);
        xfer(2, 32'hC,  1, 8'hF, 32'h0000010C, K_ACK, 32'h0, 0);
        xfer(2, 32'h10, 1, 8'hF, 32'h00000110, K_ACK, 32'h0, 0);
        xfer(2, 32'h4,  1, 8'hF, 32'h0000BAD4, K_RTY, 32'h0, 1);
        idle(2);
        push_chk("acc_count", g_dut[2].dut.acc_q == 16'd6, {16'b0, g_dut[2].dut.acc_q}, 32'd6);
        xfer(2, 32'h40, 1, 8'hF, 32'hEEEEEEEE, K_ERR, 32'h0, 1);
        idle(2);
        push_chk("acc_after_err", g_dut[2].dut.acc_q == 16'd6, {16'b0, g_dut[2].dut.acc_q}, 32'd6);
        xfer(2, 32'h0,  0, 8'hF, 32'h0, K_ACK, 32'h00000100, 1);
        xfer(2, 32'h4,  0, 8'hF, 32'h0, K_ACK, 32'h00000104, 1);
        xfer(2, 32'hC,  0, 8'hF, 32'h0, K_RTY, 32'h0, 1);
        xfer(2, 32'hC,  0, 8'hF, 32'h0, K_ACK, 32'h0000010C, 1);
        xfer(2, 32'h10, 0, 8'hF, 32'h0, K_ACK, 32'h00000110, 1);
        idle(2);

        repeat (5) @(negedge clk);
        push_chk("sb_empty", sb_q.size() == 0, 32'(sb_q.size()), 32'h0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
